hazard_scoreboard: RTL

//  Parametrised decode-stage hazard unit; replaces the fixed 2-bit pause_in/pause_out interlock.

---
 rtl/hazard_scoreboard_pkg.sv | 21 ++
 rtl/hazard_cnt_cell.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 116 +++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and helpers for the decode-stage hazard scoreboard.
package hazard_scoreboard_pkg;

    // Forward-select code meaning "operand comes straight from the regfile"
    localparam int unsigned FWD_SEL_REGFILE = 0;

    // Default pipeline latencies and register-file geometry
    localparam int unsigned DEF_NUM_REGS    = 32;
    localparam int unsigned DEF_ALU_LAT     = 2;
    localparam int unsigned DEF_LOAD_LAT    = 3;
    localparam int unsigned REG_ADDR_LENGTH = $clog2(DEF_NUM_REGS);

    // Width needed to hold the largest pending-write latency
    function automatic int unsigned cnt_width(input int unsigned alu_lat,
                                              input int unsigned load_lat);
        int unsigned max_lat;
        max_lat = (alu_lat > load_lat) ? alu_lat : load_lat;
        return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/hazard_cnt_cell.sv
// One register's pending-write down-counter: load on issue, decrement otherwise, freeze on hold.
module hazard_cnt_cell
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W = cnt_width(DEF_ALU_LAT, DEF_LOAD_LAT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: a new write overrides this cycle's decrement
    always_comb begin
        cnt_d = cnt_q;
        if (!hold) begin
            if (load) begin
                cnt_d = load_val;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: per-register pending-write counters, stall, forwarding selects
// and a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_REGS  = DEF_NUM_REGS,
    parameter int unsigned ALU_LAT   = DEF_ALU_LAT,
    parameter int unsigned LOAD_LAT  = DEF_LOAD_LAT,
    parameter int unsigned FWD_DEPTH = 1,
    parameter int unsigned PERF_W    = 16,
    localparam int unsigned AW       = $clog2(NUM_REGS),
    localparam int unsigned CNT_W    = cnt_width(ALU_LAT, LOAD_LAT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [AW-1:0]     id_rs,
    input  logic [AW-1:0]     id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_we,
    input  logic [AW-1:0]     id_wreg,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic              hold,
    output logic              stall,
    output logic [CNT_W-1:0]  fwd_rs_sel,
    output logic [CNT_W-1:0]  fwd_rt_sel,
    output logic [PERF_W-1:0] stall_cycles
);

    // Table covers every encodable address so the read muxes never index out of range
    localparam int unsigned TBL = 1 << AW;

    logic [CNT_W-1:0]  cnt_tbl [TBL];
    logic [CNT_W-1:0]  cnt_rs;
    logic [CNT_W-1:0]  cnt_rt;
    logic              rs_act;
    logic              rt_act;
    logic              haz_a;
    logic              haz_b;
    logic              stall_c;
    logic              issue;
    logic              wr_en;
    logic [CNT_W-1:0]  wr_val;
    logic [PERF_W-1:0] stall_cycles_q;
    logic [PERF_W-1:0] stall_cycles_d;

    // r0 is hardwired to "nothing pending"
    assign cnt_tbl[0] = '0;

    // One counter per tracked register; unused encodings read as zero
    for (genvar r = 1; r < TBL; r++) begin : g_reg
        if (r < NUM_REGS) begin : g_cell
            hazard_cnt_cell #(
                .CNT_W    (CNT_W)
            ) u_cell (
                .clk      (clk),
                .rst      (rst),
                .hold     (hold),
                .load     (wr_en && (id_wreg == AW'(r))),
                .load_val (wr_val),
                .cnt      (cnt_tbl[r])
            );
        end else begin : g_pad
            assign cnt_tbl[r] = '0;
        end
    end

    // Hazard detection and issue decision from pre-update counts
    always_comb begin
        cnt_rs  = cnt_tbl[id_rs];
        cnt_rt  = cnt_tbl[id_rt];
        rs_act  = id_rs_used && (id_rs != '0);
        rt_act  = id_rt_used && (id_rt != '0);
        haz_a   = id_valid && rs_act && (32'(cnt_rs) > FWD_DEPTH);
        haz_b   = id_valid && rt_act && (32'(cnt_rt) > FWD_DEPTH);
        stall_c = (haz_a || haz_b) && !flush && !rst;
        issue   = id_valid && !stall_c && !flush && !hold && !rst;
        wr_en   = issue && id_we && (id_wreg != '0);
        wr_val  = id_is_load ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);
    end

    // Zero-latency decode outputs; forced quiet while in reset
    always_comb begin
        stall      = stall_c;
        fwd_rs_sel = CNT_W'(FWD_SEL_REGFILE);
        fwd_rt_sel = CNT_W'(FWD_SEL_REGFILE);
        if (!rst && rs_act) begin
            fwd_rs_sel = cnt_rs;
        end
        if (!rst && rt_act) begin
            fwd_rt_sel = cnt_rt;
        end
    end

    // Saturating stall-cycle counter; frozen pipe cycles are not counted
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_c && !hold && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
    end

    // Perf counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule
